// File: rtl/xdma_stream_engine.sv
// XDMA user-side stream engine: per-channel H2C->C2H loopback FIFO, C2H pattern
// generator and H2C pattern checker, selected by a shared mode input.
`timescale 1ns/1ps
module xdma_stream_engine #(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_XDMA_NUM_CHNL = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int PKT_BEATS       = 256
) (
    input  logic                                        user_clk,
    input  logic                                        sys_rst,
    input  logic [1:0]                                  mode,
    input  logic [C_XDMA_NUM_CHNL*C_DATA_WIDTH-1:0]     m_axis_h2c_tdata,
    input  logic [C_XDMA_NUM_CHNL*C_DATA_WIDTH/8-1:0]   m_axis_h2c_tkeep,
    input  logic [C_XDMA_NUM_CHNL-1:0]                  m_axis_h2c_tlast,
    input  logic [C_XDMA_NUM_CHNL-1:0]                  m_axis_h2c_tvalid,
    output logic [C_XDMA_NUM_CHNL-1:0]                  m_axis_h2c_tready,
    output logic [C_XDMA_NUM_CHNL*C_DATA_WIDTH-1:0]     s_axis_c2h_tdata,
    output logic [C_XDMA_NUM_CHNL*C_DATA_WIDTH/8-1:0]   s_axis_c2h_tkeep,
    output logic [C_XDMA_NUM_CHNL-1:0]                  s_axis_c2h_tlast,
    output logic [C_XDMA_NUM_CHNL-1:0]                  s_axis_c2h_tvalid,
    input  logic [C_XDMA_NUM_CHNL-1:0]                  s_axis_c2h_tready,
    output logic [C_XDMA_NUM_CHNL-1:0]                  chk_err,
    output logic [3:0]                                  leds
);
    localparam int W     = C_DATA_WIDTH;
    localparam int KW    = C_DATA_WIDTH / 8;
    localparam int REPS  = C_DATA_WIDTH / 32;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = W + KW + 1;

    localparam logic [1:0] MODE_LOOP = 2'b00;
    localparam logic [1:0] MODE_GEN  = 2'b01;
    localparam logic [1:0] MODE_CHK  = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    logic [1:0]  mode_reg;
    logic        quiet_reg;
    logic [25:0] heartbeat_reg;
    logic        mode_change;
    logic        loop_act;
    logic        gen_act;
    logic        chk_act;

    assign mode_change = (mode != mode_reg);

    // quiet_reg marks the single dead cycle that follows every mode change
    always_ff @(posedge user_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_reg      <= MODE_IDLE;
            quiet_reg     <= 1'b1;
            heartbeat_reg <= '0;
        end else begin
            mode_reg      <= mode;
            quiet_reg     <= mode_change;
            heartbeat_reg <= heartbeat_reg + 26'd1;
        end
    end

    assign loop_act = (mode_reg == MODE_LOOP) && !quiet_reg;
    assign gen_act  = (mode_reg == MODE_GEN)  && !quiet_reg;
    assign chk_act  = (mode_reg == MODE_CHK)  && !quiet_reg;

    genvar gi;
    generate
        for (gi = 0; gi < C_XDMA_NUM_CHNL; gi++) begin : g_chnl
            logic [ENT_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic [31:0]      seq_reg;     // generator seq, or checker exp
            logic [15:0]      beat_reg;
            logic             err_reg;
            logic [W-1:0]     h2c_data;
            logic [KW-1:0]    h2c_keep;
            logic [W-1:0]     pattern;
            logic [ENT_W-1:0] head;
            logic             full;
            logic             empty;
            logic             gen_last;
            logic             h2c_xfer;
            logic             c2h_xfer;
            logic             push;
            logic             pop;
            logic             chk_bad;

            assign h2c_data = m_axis_h2c_tdata[gi*W +: W];
            assign h2c_keep = m_axis_h2c_tkeep[gi*KW +: KW];
            assign pattern  = {REPS{seq_reg}};
            assign head     = mem[rd_ptr_reg];
            assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
            assign empty    = (count_reg == '0);
            assign gen_last = (beat_reg == 16'(PKT_BEATS - 1));

            assign m_axis_h2c_tready[gi]        = (loop_act && !full) || gen_act || chk_act;
            assign s_axis_c2h_tvalid[gi]        = (loop_act && !empty) || gen_act;
            assign s_axis_c2h_tdata[gi*W +: W]  = loop_act ? head[ENT_W-1 -: W] : pattern;
            assign s_axis_c2h_tkeep[gi*KW +: KW] = loop_act ? head[KW:1] : {KW{1'b1}};
            assign s_axis_c2h_tlast[gi]         = loop_act ? head[0] : gen_last;
            assign chk_err[gi]                  = err_reg;

            assign h2c_xfer = m_axis_h2c_tready[gi] && m_axis_h2c_tvalid[gi];
            assign c2h_xfer = s_axis_c2h_tvalid[gi] && s_axis_c2h_tready[gi];
            assign push     = loop_act && h2c_xfer;
            assign pop      = loop_act && c2h_xfer;
            assign chk_bad  = (h2c_data != pattern) || (h2c_keep != {KW{1'b1}}) ||
                              (m_axis_h2c_tlast[gi] != gen_last);

            always_ff @(posedge user_clk) begin
                if (push)
                    mem[wr_ptr_reg] <= {h2c_data, h2c_keep, m_axis_h2c_tlast[gi]};
            end

            // Idle and mode changes both discard FIFO contents and restart counters
            always_ff @(posedge user_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    seq_reg    <= '0;
                    beat_reg   <= '0;
                    err_reg    <= 1'b0;
                end else if (mode_change || (mode_reg == MODE_IDLE)) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    seq_reg    <= '0;
                    beat_reg   <= '0;
                    err_reg    <= 1'b0;
                end else begin
                    if (push)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (push && !pop)
                        count_reg <= count_reg + 1'b1;
                    else if (pop && !push)
                        count_reg <= count_reg - 1'b1;
                    if ((gen_act && c2h_xfer) || (chk_act && h2c_xfer)) begin
                        seq_reg  <= seq_reg + 32'd1;
                        beat_reg <= gen_last ? 16'd0 : beat_reg + 16'd1;
                    end
                    if (chk_act && h2c_xfer && chk_bad)
                        err_reg <= 1'b1;
                end
            end
        end
    endgenerate

    assign leds = {heartbeat_reg[25], mode_reg[1], mode_reg[0], |chk_err};

endmodule

// File: doc/xdma_stream_engine.md
XDMA_STREAM_ENGINE -- requirements
Module: xdma_stream_engine

Interface
REQ-001 Parameter C_DATA_WIDTH, default 64: AXI-stream data width per channel; legal values are 64, 128, 256 and 512.
REQ-002 Parameter C_XDMA_NUM_CHNL, default 1: number of independent H2C/C2H channel pairs (1..4).
REQ-003 Parameter FIFO_DEPTH, default 16: loopback FIFO entries per channel; must be a power of 2, minimum 4.
REQ-004 Parameter PKT_BEATS, default 256: generator packet length in beats (1..65535).
REQ-005 Port user_clk  in  1: sole clock; all logic is on the rising edge.
REQ-006 Port sys_rst  in  1: reset, asynchronous assert, active-high.
REQ-007 Port mode  in  2: operating mode (00 loopback, 01 generator, 10 checker, 11 idle), shared by all channels.
REQ-008 Port m_axis_h2c_tdata/tkeep/tlast/tvalid  in  N*W / N*W/8 / N / N: H2C streams, channel c in slice c.
REQ-009 Port m_axis_h2c_tready  out  N: H2C ready per channel.
REQ-010 Port s_axis_c2h_tdata/tkeep/tlast/tvalid  out  N*W / N*W/8 / N / N: C2H streams, channel c in slice c.
REQ-011 Port s_axis_c2h_tready  in  N: C2H ready per channel.
REQ-012 Port chk_err  out  N: sticky checker mismatch flag per channel.
REQ-013 Port leds  out  4: {heartbeat[25], mode[1], mode[0], |chk_err}, MSB first.

Function
REQ-014 A beat transfers only on a cycle where tvalid and tready are both 1; once asserted, tvalid and the associated payload are held until that beat transfers.
REQ-015 mode is registered into mode_r every cycle; when mode_r changes, all of the following happen on that same edge:
- every FIFO is flushed;
- every sequence counter is cleared;
- chk_err is cleared;
- all tvalid and tready outputs are 0 for exactly one cycle.
The host quiesces traffic before changing mode.
REQ-016 Loopback (00), per channel, FIFO of FIFO_DEPTH entries holding {tdata, tkeep, tlast}:
- h2c_tready = !full;
- c2h_tvalid = !empty, with the payload taken from the FIFO head;
- latency: a beat accepted at edge k is presented on C2H from the cycle after edge k;
- simultaneous push and pop when neither full nor empty leaves the count unchanged;
- when full, h2c_tready = 0 and there is no overwrite;
- when empty, c2h_tvalid = 0;
- the read and write pointers wrap modulo FIFO_DEPTH;
- occupancy is tracked with a log2(FIFO_DEPTH)+1-bit counter.
REQ-017 Generator (01), per channel:
- c2h_tvalid = 1 continuously;
- tdata = the 32-bit sequence seq replicated W/32 times;
- tkeep = all ones;
- tlast = 1 on beat index PKT_BEATS-1 of each packet;
- seq increments on each transfer and wraps from 0xFFFFFFFF to 0;
- the beat index resets to 0 after tlast transfers;
- h2c_tready = 1 and all H2C data is discarded.
REQ-018 Checker (10), per channel:
- h2c_tready = 1 and c2h_tvalid = 0;
- each accepted beat is compared with the expected pattern, built the same way as the generator pattern from an expected counter exp;
- exp increments per accepted beat with 32-bit wrap;
- chk_err is set on a tdata mismatch, on tkeep ≠ all ones, or on a tlast value different from the generator tlast rule;
- chk_err stays set until reset or a mode change;
- exp keeps advancing after a mismatch, with no resynchronisation.
REQ-019 Idle (11): all tready and all tvalid outputs are 0; FIFO contents are discarded.
REQ-020 Channels are fully independent; backpressure on channel c does not affect any other channel.
REQ-021 A 26-bit heartbeat counter increments every cycle and wraps.
REQ-022 All outputs are driven from registers or FIFO storage; there is no combinational path from any input tdata to any output.

Reset
REQ-023 While sys_rst = 1, all of the following hold:
- all tvalid and tready = 0;
- FIFOs are empty;
- seq, exp, beat index and heartbeat = 0;
- chk_err = 0;
- mode_r = 11, so the first edge after release loads mode and counts as a mode change.
REQ-024 Reset asserted mid-packet aborts the packet immediately, with no tlast generated.

Verification
REQ-025 Loopback, N=2, W=64: send 20 beats on ch0 with c2h_tready[0]=0 -> h2c_tready[0] falls after 16 accepted beats; ch1 traffic is unaffected; after ready is released, C2H ch0 delivers the 16 beats and then the remaining 4, in order, with tkeep and tlast bit-exact.
REQ-026 Loopback throughput: single beat 0xA5A5_0000_0000_0001, with both ready signals held at 1 -> the beat appears on C2H exactly 1 cycle after acceptance; a continuous stream sustains 1 beat per cycle.
REQ-027 Generator, PKT_BEATS=4, W=128 -> the first beats are 0x00000000×4, then 0x00000001×4, and so on; tlast is set on beats 3, 7 and 11; with seq preloaded near wrap, 0xFFFFFFFF is followed by 0x00000000.
REQ-028 Checker: drive a correct generator stream -> chk_err stays 0; corrupt beat 5 by one bit -> chk_err goes to 1 on the following cycle and stays there; a subsequent mode change clears it.
REQ-029 Reset asserted mid-stream in loopback with 8 beats buffered -> all outputs go to 0 asynchronously; after release (mode=00), the FIFO is empty and no stale beat appears on C2H.
REQ-030 Mode switch 00 -> 01 with the FIFO non-empty and the host quiesced -> exactly one cycle with all tvalid/tready = 0; the generator then starts at seq 0.
